ccff_loader: RTL

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_pkg.sv | 15 +
 rtl/ccff_loader_if.sv | 12 +
 rtl/ccff_serializer.sv | 48 ++++
 rtl/ccff_loader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and defaults.
package ccff_pkg;

    localparam int CNT_W_DEF    = 20;
    localparam int PRST_CYC_DEF = 4;
    localparam int BYTE_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRST  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/ccff_loader_if.sv
// Byte-stream handshake carrying the bitstream into the loader.
interface ccff_loader_if;
    import ccff_pkg::*;

    logic [BYTE_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/ccff_serializer.sv
// Byte-to-bit serializer: holds one byte and presents it MSB first.
module ccff_serializer
    import ccff_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic              empty_o,
    output logic              bit_o
);

    logic [BYTE_W-1:0] sr_q, sr_d;
    logic [3:0]        left_q, left_d;

    // Flush discards a partial byte; otherwise load a fresh byte or shift one bit out.
    always_comb begin
        sr_d   = sr_q;
        left_d = left_q;
        if (flush_i) begin
            sr_d   = '0;
            left_d = '0;
        end else if (load_i) begin
            sr_d   = data_i;
            left_d = 4'(BYTE_W);
        end else if (pop_i && (left_q != 4'd0)) begin
            sr_d   = {sr_q[BYTE_W-2:0], 1'b0};
            left_d = left_q - 4'd1;
        end
    end

    // Shift register and remaining-bit count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q   <= '0;
            left_q <= '0;
        end else begin
            sr_q   <= sr_d;
            left_q <= left_d;
        end
    end

    assign empty_o = (left_q == 4'd0);
    assign bit_o   = sr_q[BYTE_W-1];

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: resets the fabric chain, then shifts a byte
// stream into it bit by bit with a registered prog_clk, and reports tail parity.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PRST_CYC = PRST_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_bits,
    ccff_loader_if.slave     s_bus,
    output logic             prog_clk,
    output logic             prog_reset,
    output logic             ccff_head,
    input  logic             ccff_tail,
    output logic             isol_n,
    output logic             busy,
    output logic             done,
    output logic             tail_parity
);

    localparam int            PW        = (PRST_CYC > 1) ? $clog2(PRST_CYC) : 1;
    localparam logic [PW-1:0] PRST_LAST = PW'(PRST_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] nbits_q, nbits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    prst_q, prst_d;
    logic             parity_q, parity_d;
    logic             pclk_q, pclk_d;
    logic             head_q, head_d;
    logic             isol_q, isol_d;
    // arm_q: head was just updated (phase A), raise prog_clk next cycle (phase B).
    logic             arm_q, arm_d;

    logic ser_load, ser_pop, ser_flush, ser_empty, ser_bit;
    logic rdy;

    ccff_serializer u_ser (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ser_load),
        .data_i  (s_bus.s_data),
        .pop_i   (ser_pop),
        .flush_i (ser_flush),
        .empty_o (ser_empty),
        .bit_o   (ser_bit)
    );

    // Next-state and datapath control; each bit spends one cycle in phase A and one in phase B.
    always_comb begin
        state_d   = state_q;
        nbits_d   = nbits_q;
        cnt_d     = cnt_q;
        prst_d    = prst_q;
        parity_d  = parity_q;
        pclk_d    = 1'b0;
        head_d    = head_q;
        isol_d    = isol_q;
        arm_d     = 1'b0;
        ser_load  = 1'b0;
        ser_pop   = 1'b0;
        ser_flush = 1'b0;
        rdy       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    nbits_d   = num_bits;
                    cnt_d     = '0;
                    prst_d    = '0;
                    parity_d  = 1'b0;
                    isol_d    = 1'b0;
                    ser_flush = 1'b1;
                    state_d   = PRST;
                end
            end
            PRST: begin
                if (prst_q == PRST_LAST) begin
                    state_d = SHIFT;
                end else begin
                    prst_d = prst_q + PW'(1);
                end
            end
            SHIFT: begin
                // The chain's tail is sampled while prog_clk is high.
                if (pclk_q) begin
                    parity_d = parity_q ^ ccff_tail;
                end
                if (arm_q) begin
                    pclk_d = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (cnt_q == nbits_q) begin
                    ser_flush = 1'b1;
                    isol_d    = 1'b1;
                    state_d   = FIN;
                end else if (!ser_empty) begin
                    head_d  = ser_bit;
                    ser_pop = 1'b1;
                    arm_d   = 1'b1;
                end else begin
                    // Empty and bits remain: ask for a byte; without one we simply stall.
                    rdy      = 1'b1;
                    ser_load = s_bus.s_valid;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered chain outputs; reset aborts any load at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            nbits_q  <= '0;
            cnt_q    <= '0;
            prst_q   <= '0;
            parity_q <= 1'b0;
            pclk_q   <= 1'b0;
            head_q   <= 1'b0;
            isol_q   <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nbits_q  <= nbits_d;
            cnt_q    <= cnt_d;
            prst_q   <= prst_d;
            parity_q <= parity_d;
            pclk_q   <= pclk_d;
            head_q   <= head_d;
            isol_q   <= isol_d;
            arm_q    <= arm_d;
        end
    end

    assign s_bus.s_ready = rdy;
    assign prog_clk      = pclk_q;
    assign prog_reset    = reset | (state_q == PRST);
    assign ccff_head     = head_q;
    assign isol_n        = isol_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FIN);
    assign tail_parity   = parity_q;

endmodule
